nvme_pcie_master_arb: RTL and testbench

- Arbitrates NUM_REQ requesters onto the single-outstanding pulse write/read interface of the NVMe PCIe master (pcie_write/pcie_read in; *done/*error back). Requesters are the admin-queue doorbell writer, the I/O-queue doorbell writer and the controller-register reader/initialiser.
- Sequences exactly one transaction at a time, returns read data and status to the winner, and enforces a completion timeout.

---
 rtl/nvme_pcie_arb_pkg.sv | 20 ++
 rtl/nvme_pcie_master_arb_if.sv | 29 ++
 rtl/nvme_pcie_master_arb_rr.sv | 31 +++
 rtl/nvme_pcie_master_arb.sv | 174 +++++++++++++++++
 tb/tb_nvme_pcie_master_arb.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/nvme_pcie_arb_pkg.sv
// Shared types and helpers for the NVMe PCIe master request arbiter.
package nvme_pcie_arb_pkg;

    // Arbiter sequencing states; one transaction is in flight from ISSUE to RESP.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    // Completion timeout used when the instantiating code does not override it.
    localparam int DEFAULT_TIMEOUT_CYCLES = 4096;

    // Width of a requester index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/nvme_pcie_master_arb_if.sv
// Pulse-style write/read bus between the arbiter and the NVMe PCIe master.
//
// Handshake: the master raises pcie_write or pcie_read for exactly one cycle
// with the address (and write data) valid that cycle and held until the next
// issue. The slave answers later with a one-cycle pcie_wdone / pcie_rdone;
// pcie_werror / pcie_rerror and pcie_rdata are only meaningful in that cycle.
// There is no ready signal: at most one transaction is outstanding.
interface nvme_pcie_master_arb_if;
    logic        pcie_write;
    logic [31:0] pcie_waddr;
    logic [31:0] pcie_wdata;
    logic        pcie_wdone;
    logic        pcie_werror;
    logic        pcie_read;
    logic [31:0] pcie_raddr;
    logic [31:0] pcie_rdata;
    logic        pcie_rdone;
    logic        pcie_rerror;

    modport master (
        output pcie_write, pcie_waddr, pcie_wdata, pcie_read, pcie_raddr,
        input  pcie_wdone, pcie_werror, pcie_rdata, pcie_rdone, pcie_rerror
    );

    modport slave (
        input  pcie_write, pcie_waddr, pcie_wdata, pcie_read, pcie_raddr,
        output pcie_wdone, pcie_werror, pcie_rdata, pcie_rdone, pcie_rerror
    );
endinterface

// File: rtl/nvme_pcie_master_arb_rr.sv
// Combinational round-robin pick: lowest requesting index at or after ptr, wrapping.
module nvme_rr_arbiter
    import nvme_pcie_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               any,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx
);

    // Walk offsets from farthest to nearest so the nearest requester overwrites.
    always_comb begin
        any   = |req;
        grant = '0;
        idx   = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (req[j] && (j == (int'(ptr) + off) % NUM_REQ)) begin
                    grant    = '0;
                    grant[j] = 1'b1;
                    idx      = IDX_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/nvme_pcie_master_arb.sv
// Serialises admin doorbell, I/O doorbell and register accesses onto the
// single-outstanding PCIe master bus with round-robin fairness and a timeout.
module nvme_pcie_master_arb
    import nvme_pcie_arb_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int ADDR_BITS      = 32,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                          axi_aclk,
    input  logic                          axi_aresetn,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_BITS-1:0]  req_addr,
    input  logic [NUM_REQ*32-1:0]         req_wdata,
    output logic [NUM_REQ-1:0]            rsp_done,
    output logic [31:0]                   rsp_rdata,
    output logic                          rsp_error,
    output logic                          rsp_timeout,
    output logic                          busy,
    output arb_state_t                    dbg_state,
    nvme_pcie_master_arb_if.master        pcie
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    arb_state_t          state, next_state;
    logic [IDX_W-1:0]    win_idx, d_win_idx, ptr, d_ptr, arb_idx;
    logic                win_write, d_win_write;
    logic [CNT_W-1:0]    cnt, d_cnt;
    logic [NUM_REQ-1:0]  arb_grant;
    logic                arb_any;
    logic [31:0]         sel_addr, sel_wdata;
    logic                sel_write, wait_done, wait_err, timeout_hit;
    logic                d_pcie_write, d_pcie_read, d_rsp_error, d_rsp_timeout, d_busy;
    logic [31:0]         d_waddr, d_wdata, d_raddr, d_rsp_rdata;
    logic [NUM_REQ-1:0]  d_rsp_done;

    nvme_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
        .req   (req_valid),
        .ptr   (ptr),
        .any   (arb_any),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    assign dbg_state = state;
    assign sel_write = |(req_write & arb_grant);

    // Only the completion matching the in-flight direction counts.
    assign wait_done   = win_write ? pcie.pcie_wdone  : pcie.pcie_rdone;
    assign wait_err    = win_write ? pcie.pcie_werror : pcie.pcie_rerror;
    assign timeout_hit = TO_EN && (cnt == CNT_LIMIT);

    // Mux the granted requester's address (zero-extended) and write data.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) begin
                sel_addr  = 32'(req_addr[i*ADDR_BITS +: ADDR_BITS]);
                sel_wdata = req_wdata[i*32 +: 32];
            end
        end
    end

    // State register.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) state <= IDLE;
        else              state <= next_state;
    end

    // Next-state decode; a done beats a timeout landing in the same cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (arb_any) next_state = ISSUE;
            ISSUE: next_state = WAIT;
            WAIT:  if (wait_done || timeout_hit) next_state = RESP;
            RESP:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Next values of every registered output, latch and counter.
    always_comb begin
        d_win_idx     = win_idx;
        d_win_write   = win_write;
        d_ptr         = ptr;
        d_cnt         = cnt;
        d_pcie_write  = 1'b0;
        d_pcie_read   = 1'b0;
        d_waddr       = pcie.pcie_waddr;
        d_wdata       = pcie.pcie_wdata;
        d_raddr       = pcie.pcie_raddr;
        d_rsp_done    = '0;
        d_rsp_rdata   = '0;
        d_rsp_error   = 1'b0;
        d_rsp_timeout = 1'b0;
        d_busy        = (next_state != IDLE);
        case (state)
            IDLE: begin
                if (arb_any) begin
                    d_win_idx   = arb_idx;
                    d_win_write = sel_write;
                    if (sel_write) begin
                        d_pcie_write = 1'b1;
                        d_waddr      = sel_addr;
                        d_wdata      = sel_wdata;
                    end else begin
                        d_pcie_read  = 1'b1;
                        d_raddr      = sel_addr;
                    end
                end
            end
            ISSUE: d_cnt = '0;
            WAIT: begin
                if (wait_done) begin
                    d_rsp_done  = NUM_REQ'(1) << win_idx;
                    d_rsp_rdata = win_write ? 32'h0 : pcie.pcie_rdata;
                    d_rsp_error = wait_err;
                end else if (timeout_hit) begin
                    d_rsp_done    = NUM_REQ'(1) << win_idx;
                    d_rsp_error   = 1'b1;
                    d_rsp_timeout = 1'b1;
                end else if (cnt != CNT_MAX) begin
                    d_cnt = cnt + CNT_W'(1);
                end
            end
            RESP: d_ptr = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + IDX_W'(1);
            default: ;
        endcase
    end

    // Output and datapath registers; reset also kills any in-flight pulse.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            win_idx         <= '0;
            win_write       <= 1'b0;
            ptr             <= '0;
            cnt             <= '0;
            pcie.pcie_write <= 1'b0;
            pcie.pcie_read  <= 1'b0;
            pcie.pcie_waddr <= '0;
            pcie.pcie_wdata <= '0;
            pcie.pcie_raddr <= '0;
            rsp_done        <= '0;
            rsp_rdata       <= '0;
            rsp_error       <= 1'b0;
            rsp_timeout     <= 1'b0;
            busy            <= 1'b0;
        end else begin
            win_idx         <= d_win_idx;
            win_write       <= d_win_write;
            ptr             <= d_ptr;
            cnt             <= d_cnt;
            pcie.pcie_write <= d_pcie_write;
            pcie.pcie_read  <= d_pcie_read;
            pcie.pcie_waddr <= d_waddr;
            pcie.pcie_wdata <= d_wdata;
            pcie.pcie_raddr <= d_raddr;
            rsp_done        <= d_rsp_done;
            rsp_rdata       <= d_rsp_rdata;
            rsp_error       <= d_rsp_error;
            rsp_timeout     <= d_rsp_timeout;
            busy            <= d_busy;
        end
    end

endmodule

// File: tb/tb_nvme_pcie_master_arb.sv
// Directed bench for nvme_pcie_master_arb: vector table plus corner sequences.
module tb_nvme_pcie_master_arb;
    import nvme_pcie_arb_pkg::*;

    localparam int NUM_REQ = 3;
    localparam int ADDR_BITS = 32;
    localparam int TO_CYC = 16;

    // ---------------- clock / reset ----------------
    logic axi_aclk = 1'b0;
    logic axi_aresetn = 1'b0;
    always #5 axi_aclk = ~axi_aclk;

    logic [NUM_REQ-1:0]           req_valid, req_write;
    logic [NUM_REQ*ADDR_BITS-1:0] req_addr;
    logic [NUM_REQ*32-1:0]        req_wdata;
    logic [NUM_REQ-1:0]           rsp_done;
    logic [31:0]                  rsp_rdata;
    logic                         rsp_error, rsp_timeout, busy;
    arb_state_t                   dbg_state;

    nvme_pcie_master_arb_if pcie_bus();

    nvme_pcie_master_arb #(
        .NUM_REQ(NUM_REQ), .ADDR_BITS(ADDR_BITS), .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .axi_aclk    (axi_aclk),
        .axi_aresetn (axi_aresetn),
        .req_valid   (req_valid),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_done    (rsp_done),
        .rsp_rdata   (rsp_rdata),
        .rsp_error   (rsp_error),
        .rsp_timeout (rsp_timeout),
        .busy        (busy),
        .dbg_state   (dbg_state),
        .pcie        (pcie_bus)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_req(input int idx, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        req_write[idx]               = wr;
        req_addr[idx*ADDR_BITS +: 32] = addr;
        req_wdata[idx*32 +: 32]      = wdata;
        req_valid[idx]               = 1'b1;
    endtask

    task automatic clr_bus_in();
        pcie_bus.pcie_wdone  = 1'b0;
        pcie_bus.pcie_werror = 1'b0;
        pcie_bus.pcie_rdone  = 1'b0;
        pcie_bus.pcie_rerror = 1'b0;
        pcie_bus.pcie_rdata  = 32'hFFFF_FFFF;
    endtask

    typedef struct {
        int          req;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          done_dly;   // cycles after pulse for the matching done; 0 = never
        logic        done_err;
        logic [31:0] rdata;
        int          stray_dly;  // cycles after pulse for an opposite-direction done; 0 = none
        int          exp_at;     // cycles after pulse at which rsp_done is expected
        logic [2:0]  exp_done;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_to;
    } vec_t;

    vec_t vecs[7];

    // Issue one request from an idle DUT, answer it, and check the response.
    // Returns at the negedge of the response cycle with the request dropped.
    task automatic run_vec(input vec_t v, input string tag);
        logic early;
        early = 1'b0;
        @(negedge axi_aclk);
        set_req(v.req, v.wr, v.addr, v.wdata);
        @(negedge axi_aclk);
        chk({tag, "_pulse"}, {30'd0, pcie_bus.pcie_write, pcie_bus.pcie_read}, v.wr ? 32'd2 : 32'd1);
        if (v.wr) begin
            chk({tag, "_waddr"}, pcie_bus.pcie_waddr, v.addr);
            chk({tag, "_wdata"}, pcie_bus.pcie_wdata, v.wdata);
        end else begin
            chk({tag, "_raddr"}, pcie_bus.pcie_raddr, v.addr);
        end
        for (int c = 1; c <= v.exp_at; c++) begin
            @(negedge axi_aclk);
            clr_bus_in();
            if (c == v.done_dly) begin
                if (v.wr) begin
                    pcie_bus.pcie_wdone  = 1'b1;
                    pcie_bus.pcie_werror = v.done_err;
                end else begin
                    pcie_bus.pcie_rdone  = 1'b1;
                    pcie_bus.pcie_rerror = v.done_err;
                    pcie_bus.pcie_rdata  = v.rdata;
                end
            end
            if (c == v.stray_dly) begin
                if (v.wr) begin
                    pcie_bus.pcie_rdone  = 1'b1;
                    pcie_bus.pcie_rerror = 1'b1;
                    pcie_bus.pcie_rdata  = 32'h5A5A_5A5A;
                end else begin
                    pcie_bus.pcie_wdone  = 1'b1;
                    pcie_bus.pcie_werror = 1'b1;
                end
            end
            if (c == 1)
                chk({tag, "_pulse_width"}, {30'd0, pcie_bus.pcie_write, pcie_bus.pcie_read}, 32'd0);
            if (c < v.exp_at && rsp_done != '0) early = 1'b1;
        end
        chk({tag, "_no_early_rsp"}, {31'd0, early}, 32'd0);
        chk({tag, "_rsp_done"}, {29'd0, rsp_done}, {29'd0, v.exp_done});
        chk({tag, "_rsp_rdata"}, rsp_rdata, v.exp_rdata);
        chk({tag, "_rsp_error"}, {31'd0, rsp_error}, {31'd0, v.exp_err});
        chk({tag, "_rsp_timeout"}, {31'd0, rsp_timeout}, {31'd0, v.exp_to});
        clr_bus_in();
        req_valid[v.req] = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main test ----------------
    initial begin
        vec_t tv;
        logic seen;
        int got, last_pulse;
        logic pend;

        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        clr_bus_in();

        //            req wr    addr           wdata          dly err  rdata          stray at  done    exp_rdata      err  to
        vecs[0] = '{1, 1'b1, 32'h0000_1008, 32'hDEAD_BEEF, 5,  1'b0, 32'h0,         0,    6,  3'b010, 32'h0,         1'b0, 1'b0};
        vecs[1] = '{0, 1'b0, 32'h0000_001C, 32'h0,         3,  1'b1, 32'h0046_0001, 0,    4,  3'b001, 32'h0046_0001, 1'b1, 1'b0};
        vecs[2] = '{2, 1'b0, 32'hABCD_0000, 32'h0,         0,  1'b0, 32'h0,         0,    17, 3'b100, 32'h0,         1'b1, 1'b1};
        vecs[3] = '{0, 1'b0, 32'h0000_2000, 32'h0,         16, 1'b0, 32'h1234_5678, 0,    17, 3'b001, 32'h1234_5678, 1'b0, 1'b0};
        vecs[4] = '{1, 1'b0, 32'h0000_3000, 32'h0,         6,  1'b0, 32'hCAFE_F00D, 2,    7,  3'b010, 32'hCAFE_F00D, 1'b0, 1'b0};
        vecs[5] = '{2, 1'b1, 32'h0000_0044, 32'h55AA_55AA, 1,  1'b1, 32'h0,         0,    2,  3'b100, 32'h0,         1'b1, 1'b0};
        vecs[6] = '{0, 1'b1, 32'h0000_0008, 32'h0102_0304, 15, 1'b0, 32'h0,         3,    16, 3'b001, 32'h0,         1'b0, 1'b0};

        // Reset state, during and just after reset.
        @(negedge axi_aclk);
        @(negedge axi_aclk);
        chk("reset_ctl", {24'd0, rsp_done, rsp_error, rsp_timeout, busy, pcie_bus.pcie_write, pcie_bus.pcie_read}, 32'd0);
        chk("reset_data", rsp_rdata | pcie_bus.pcie_waddr | pcie_bus.pcie_wdata | pcie_bus.pcie_raddr, 32'd0);
        axi_aresetn = 1'b1;
        @(negedge axi_aclk);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_state", {30'd0, dbg_state}, {30'd0, IDLE});

        // Table-driven transactions.
        for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Timeout followed by a late rdone in IDLE, which must be discarded.
        tv = '{1, 1'b0, 32'h0000_0060, 32'h0, 0, 1'b0, 32'h0, 0, 17, 3'b010, 32'h0, 1'b1, 1'b1};
        run_vec(tv, "late_to");
        @(negedge axi_aclk);
        pcie_bus.pcie_rdone = 1'b1;
        pcie_bus.pcie_rdata = 32'h0000_0077;
        @(negedge axi_aclk);
        clr_bus_in();
        seen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge axi_aclk);
            if (rsp_done != '0 || busy) seen = 1'b1;
        end
        chk("late_rdone_ignored", {31'd0, seen}, 32'd0);

        // Reset in the middle of WAIT clears everything immediately.
        @(negedge axi_aclk);
        set_req(0, 1'b0, 32'h0000_0500, 32'h0);
        @(negedge axi_aclk);
        @(negedge axi_aclk);
        @(negedge axi_aclk);
        chk("pre_reset_busy", {31'd0, busy}, 32'd1);
        axi_aresetn = 1'b0;
        #1;
        chk("midreset_ctl", {24'd0, rsp_done, rsp_error, rsp_timeout, busy, pcie_bus.pcie_write, pcie_bus.pcie_read}, 32'd0);
        chk("midreset_data", rsp_rdata | pcie_bus.pcie_waddr | pcie_bus.pcie_wdata | pcie_bus.pcie_raddr, 32'd0);
        chk("midreset_state", {30'd0, dbg_state}, {30'd0, IDLE});
        req_valid = '0;
        @(negedge axi_aclk);
        axi_aresetn = 1'b1;
        tv = '{2, 1'b1, 32'h0000_0900, 32'h0000_A5A5, 2, 1'b0, 32'h0, 0, 3, 3'b100, 32'h0, 1'b0, 1'b0};
        run_vec(tv, "post_reset");

        // Round-robin with all three requesters held valid; pointer is now 0.
        exp_q = '{32'd1, 32'd2, 32'd4, 32'd1, 32'd2, 32'd4};
        @(negedge axi_aclk);
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 32'h0000_0010 + 32'(i) * 32'h100, 32'(i));
        pend = 1'b0;
        got = 0;
        last_pulse = -1;
        for (int cyc = 0; cyc < 80 && got < 6; cyc++) begin
            @(negedge axi_aclk);
            pcie_bus.pcie_wdone = pend;
            pend = 1'b0;
            if (pcie_bus.pcie_write || pcie_bus.pcie_read) begin
                if (last_pulse >= 0) chk("rr_pulse_gap", 32'(cyc - last_pulse), 32'd4);
                last_pulse = cyc;
                pend = 1'b1;
            end
            if (rsp_done != '0) begin
                if (exp_q.size() > 0) chk($sformatf("rr_grant%0d", got), {29'd0, rsp_done}, exp_q.pop_front());
                got++;
                if (got == 6) req_valid = '0;
            end
        end
        clr_bus_in();
        chk("rr_count", 32'(got), 32'd6);
        chk("rr_queue_empty", 32'(exp_q.size()), 32'd0);

        // ---------------- final report ----------------
        repeat (3) @(negedge axi_aclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
